operate_ctrl: RTL
=================

OPERATE_CTRL -- requirements
Module: operate_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 480000, SHALL be the number of consecutive stable cycles required to accept a button level change (10 ms at 48 MHz).
REQ-002 Parameter LONG_PRESS_CYCLES, default 96000000, SHALL be the number of debounced-held cycles that classify a press as long (2 s at 48 MHz).
REQ-003 Parameter BTN_ACTIVE_LOW, default 1, SHALL invert btn_raw when 1, for a pulled-up push button.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock, driven from the SB_HFOSC CLKHF output; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-006 Port btn_raw, input, 1 bit, SHALL be the asynchronous push-button pin.
REQ-007 Port operate, output, 2 bits, SHALL be the registered mode code that feeds the top-level LED case select.
REQ-008 Port mode_changed, output, 1 bit, SHALL be a one-cycle pulse on every operate update.
REQ-009 Port btn_db, output, 1 bit, SHALL be the debounced active-high button level.

Function
REQ-010 btn_raw SHALL pass through a 2-flop synchronizer, then be polarity-corrected per BTN_ACTIVE_LOW to form btn_s, an active-high level.
REQ-011 The debounce counter SHALL clear in every cycle where btn_s == btn_db, and increment when they differ.
REQ-012 btn_db SHALL take the value of btn_s on the edge that completes the DEBOUNCE_CYCLES-th consecutive differing cycle; the counter clears on that same edge.
REQ-013 A disagreement shorter than DEBOUNCE_CYCLES SHALL leave btn_db unchanged.
REQ-014 The FSM SHALL have exactly three states: IDLE, HELD and LONG.
REQ-015 IDLE -> HELD SHALL occur when btn_db == 1; the hold counter clears on entry.
REQ-016 In HELD with btn_db == 0 (short press): operate SHALL become (operate + 1) mod 4, mode_changed SHALL pulse, and the FSM SHALL go to IDLE, all on that edge.
REQ-017 In HELD with btn_db == 1: the hold counter SHALL increment.
REQ-018 In HELD, on the edge where the hold counter reaches LONG_PRESS_CYCLES-1 while btn_db == 1 (long press): operate SHALL become 2'b00, mode_changed SHALL pulse, and the FSM SHALL go to LONG.
REQ-019 LONG SHALL hold until btn_db == 0, then go to IDLE with no operate change and no pulse.
REQ-020 Wrap-around: a short press at operate == 2'b11 SHALL yield 2'b00 with a pulse.
REQ-021 A long press at operate == 2'b00 SHALL still pulse mode_changed.
REQ-022 Short-press latency SHALL be: operate and mode_changed update exactly 1 cycle after btn_db falls.
REQ-023 The hold counter SHALL be sized as ceil(log2(LONG_PRESS_CYCLES+1)) and SHALL saturate rather than wrap.
REQ-024 The debounce counter SHALL be sized as ceil(log2(DEBOUNCE_CYCLES+1)) and SHALL saturate rather than wrap.
REQ-025 mode_changed SHALL never be high for two consecutive cycles.
REQ-026 operate SHALL change only together with a mode_changed pulse.

Reset
REQ-027 While rst is high at a clock edge, the following SHALL clear: operate = 2'b00, mode_changed = 0, btn_db = 0, both synchronizer flops at the inactive pin level, both counters = 0, FSM = IDLE.
REQ-028 Reset asserted mid-press (HELD or LONG) SHALL abort the press with no pulse.
REQ-029 After reset, a button still held SHALL register as a new press only once it has been debounced afresh.
REQ-030 rst SHALL take priority over all other events in the same cycle.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, BTN_ACTIVE_LOW=1)
REQ-031 Glitch rejection: drive btn_raw low for 3 cycles, then high -> btn_db stays 0, operate stays 2'b00, no pulse.
REQ-032 Short presses: apply four presses of 10 cycles each with 10-cycle gaps -> operate steps 01, 10, 11, 00, with exactly four single-cycle pulses, each 1 cycle after btn_db falls.
REQ-033 Long press: from operate = 2'b10, hold the button for 40 cycles -> operate = 2'b00 with one pulse 20 cycles after btn_db rises, and no further change on release.
REQ-034 Reset mid-press: assert rst for 1 cycle during HELD at operate = 2'b01, keep btn_raw low -> operate = 2'b00 with no pulse; release then -> no pulse, and the next press increments to 2'b01.
REQ-035 Bounce: toggle btn_raw every 2 cycles for 20 cycles, then settle low for 10 cycles -> exactly one btn_db rise, after 4 stable cycles.
REQ-036 Boundary: hold the button for exactly 19 debounced cycles -> classified as a short press, operate increments; hold for 20 -> classified as long, operate = 2'b00.

Source files
------------

// File: rtl/operate_ctrl.sv
// Push-button mode controller: synchronizes and debounces a button pin, then
// classifies each press as short (advance mode) or long (return to mode 0).
module operate_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES   = 480000,
  parameter int unsigned LONG_PRESS_CYCLES = 96000000,
  parameter bit          BTN_ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic [1:0] operate,
  output logic       mode_changed,
  output logic       btn_db
);

  // Counter widths and thresholds
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_MAX    = '1;
  localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

  // Pin level when the button is not pressed
  localparam logic PIN_IDLE = BTN_ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  logic              sync1;
  logic              sync2;
  logic              btn_s;
  logic [DB_W-1:0]   db_cnt;

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [HOLD_W-1:0] hold_inc;
  logic [1:0]        operate_nxt;
  logic              mode_changed_nxt;

  // Two-flop synchronizer; resets to the idle pin level so no press is seen
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= PIN_IDLE;
      sync2 <= PIN_IDLE;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Active-high synchronized level
  assign btn_s = sync2 ^ BTN_ACTIVE_LOW;

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreements
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else if (db_cnt != DB_MAX) begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Saturating increment of the hold counter
  assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);

  // State, hold counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      operate      <= 2'b00;
      mode_changed <= 1'b0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_nxt;
      operate      <= operate_nxt;
      mode_changed <= mode_changed_nxt;
    end
  end

  // Press classification; long press fires on the edge the count reaches LONG_PRESS_CYCLES-1
  always_comb begin
    state_nxt        = state;
    hold_nxt         = hold_cnt;
    operate_nxt      = operate;
    mode_changed_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (btn_db) begin
          state_nxt = HELD;
          hold_nxt  = '0;
        end
      end
      HELD: begin
        if (!btn_db) begin
          operate_nxt      = operate + 2'd1;
          mode_changed_nxt = 1'b1;
          state_nxt        = IDLE;
        end else begin
          hold_nxt = hold_inc;
          if (hold_inc == HOLD_LONG) begin
            operate_nxt      = 2'b00;
            mode_changed_nxt = 1'b1;
            state_nxt        = LONG;
          end
        end
      end
      LONG: begin
        if (!btn_db) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
